// File: rtl/csel_adder_pipe.sv
`default_nettype none
// =============================================================================
// Module      : csel_adder_pipe
// Description : Pipelined carry-select adder, one BLOCK-bit slice per stage,
//               with a single global valid/ready advance for the whole pipe.
// Revision    : 1.0 - initial release
// =============================================================================
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLOCK;

    // 2:1 select stage: c = s ? b : a
    function automatic logic mux2(input logic a_i, input logic b_i, input logic s_i);
        return s_i ? b_i : a_i;
    endfunction

    logic w_adv;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int RW = WIDTH - k * BLOCK;  // operand bits still to be added
        localparam int LW = k * BLOCK;          // finished lower sum bits

        logic [RW-1:0]         w_a;
        logic [RW-1:0]         w_b;
        logic                  w_c;
        logic                  w_v;
        logic [BLOCK:0]        w_s0;
        logic [BLOCK:0]        w_s1;
        logic [BLOCK:0]        w_sel;
        logic [LW+BLOCK-1:0]   sum_d;
        logic [LW+BLOCK-1:0]   sum_q;
        logic                  cy_q;
        logic                  vld_q;

        if (k == 0) begin : g_head
            assign w_a   = a;
            assign w_b   = b;
            assign w_c   = cin;
            assign w_v   = in_valid;
            assign sum_d = w_sel[BLOCK-1:0];
        end else begin : g_body
            assign w_a   = g_stage[k-1].g_fwd.a_q;
            assign w_b   = g_stage[k-1].g_fwd.b_q;
            assign w_c   = g_stage[k-1].cy_q;
            assign w_v   = g_stage[k-1].vld_q;
            assign sum_d = {w_sel[BLOCK-1:0], g_stage[k-1].sum_q};
        end

        assign w_s0 = {1'b0, w_a[BLOCK-1:0]} + {1'b0, w_b[BLOCK-1:0]};
        assign w_s1 = {1'b0, w_a[BLOCK-1:0]} + {1'b0, w_b[BLOCK-1:0]}
                    + {{BLOCK{1'b0}}, 1'b1};

        for (genvar i = 0; i <= BLOCK; i++) begin : g_sel
            assign w_sel[i] = mux2(w_s0[i], w_s1[i], w_c);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (w_adv) begin
                vld_q <= w_v;
                cy_q  <= w_sel[BLOCK];
                sum_q <= sum_d;
            end
        end

        // Upper operand slices ride along until their own stage consumes them
        if (k < NBLK - 1) begin : g_fwd
            logic [RW-BLOCK-1:0] a_q;
            logic [RW-BLOCK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (w_adv) begin
                    a_q <= w_a[RW-1:BLOCK];
                    b_q <= w_b[RW-1:BLOCK];
                end
            end
        end
    end

    assign out_valid = g_stage[NBLK-1].vld_q;
    assign sum       = g_stage[NBLK-1].sum_q;
    assign cout      = g_stage[NBLK-1].cy_q;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv && rst_n;

endmodule
`default_nettype wire

// File: tb/tb_csel_adder_pipe.sv
`default_nettype none
// =============================================================================
// Module      : tb_csel_adder_pipe
// Description : Scoreboard bench for csel_adder_pipe at BLOCK = 4, 16 and 1.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_csel_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_v  [3];
    logic        out_ready_v [3];
    logic        cin_v       [3];
    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic        cout_v      [3];
    logic [15:0] a_v         [3];
    logic [15:0] b_v         [3];
    logic [15:0] sum_v       [3];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          lat_of [3] = '{4, 1, 16};
    logic [16:0] exp_q [$];

    csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .sum(sum_v[0]), .cout(cout_v[0])
    );

    csel_adder_pipe #(.WIDTH(16), .BLOCK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .sum(sum_v[1]), .cout(cout_v[1])
    );

    csel_adder_pipe #(.WIDTH(16), .BLOCK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .sum(sum_v[2]), .cout(cout_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic r);
        in_valid_v[idx]  = v;
        a_v[idx]         = a;
        b_v[idx]         = b;
        cin_v[idx]       = c;
        out_ready_v[idx] = r;
    endtask

    // Called right after inputs are driven at a falling edge
    task automatic step(input int idx);
        #1;
        if (out_valid_v[idx] && out_ready_v[idx]) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid_v[idx]), 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(sum_v[idx]), 32'(e[15:0]));
                check("sb_cout", 32'(cout_v[idx]), 32'(e[16]));
            end
        end
        if (in_valid_v[idx] && in_ready_v[idx])
            exp_q.push_back({1'b0, a_v[idx]} + {1'b0, b_v[idx]} + {16'd0, cin_v[idx]});
    endtask

    task automatic single(input int idx, input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] es, input logic ec, input string tag);
        @(negedge clk);
        drive(idx, 1'b1, a, b, c, 1'b1);
        #1;
        check({tag, "_rdy"}, 32'(in_ready_v[idx]), 32'd1);
        for (int i = 1; i <= lat_of[idx]; i++) begin
            @(negedge clk);
            if (i == 1) in_valid_v[idx] = 1'b0;
            #1;
            check({tag, "_lat"}, 32'(out_valid_v[idx]), 32'(i == lat_of[idx]));
        end
        check({tag, "_sum"}, 32'(sum_v[idx]), 32'(es));
        check({tag, "_cout"}, 32'(cout_v[idx]), 32'(ec));
        @(negedge clk);
        #1;
        check({tag, "_gone"}, 32'(out_valid_v[idx]), 32'd0);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_run(input int idx);
        int   sent = 0;
        int   cyc  = 0;
        logic pend = 1'b0;
        exp_q.delete();
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!pend) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0)
                    drive(idx, 1'b1, rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b1);
                else
                    in_valid_v[idx] = 1'b0;
            end
            out_ready_v[idx] = ($urandom_range(0, 3) != 0);
            step(idx);
            if (in_valid_v[idx] && in_ready_v[idx]) sent++;
            pend = in_valid_v[idx] && !in_ready_v[idx];
        end
        check("rand_sent", 32'(sent), 32'd1000);
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        in_valid_v[idx]  = 1'b0;
        out_ready_v[idx] = 1'b1;
    endtask

    logic [15:0] ta [3] = '{16'h1111, 16'h0F0F, 16'h8000};
    logic [15:0] tb [3] = '{16'h2222, 16'h00F1, 16'h8000};
    logic [16:0] tr [3] = '{17'h03333, 17'h01000, 17'h10000};
    logic [15:0] sa [5] = '{16'hFFFF, 16'h1234, 16'hA5A5, 16'h0001, 16'h7777};
    logic [15:0] sb [5] = '{16'h0001, 16'hEDCC, 16'h5A5A, 16'hFFFE, 16'h8889};

    initial begin
        logic [15:0] hold_s;
        logic        hold_c;
        hold_s = '0;
        hold_c = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(in_ready_v[i]), 32'd0);
            check("rst_out_valid", 32'(out_valid_v[i]), 32'd0);
            check("rst_sum", 32'(sum_v[i]), 32'd0);
            check("rst_cout", 32'(cout_v[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        single(0, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, "ripple");
        single(0, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, "xcarry");
        single(0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "allones");
        single(1, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, "ripple_b16");
        single(2, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, "ripple_b1");

        // Back-to-back accepts, results on three consecutive cycles
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 3) drive(0, 1'b1, ta[i], tb[i], 1'b0, 1'b1);
            else       in_valid_v[0] = 1'b0;
            step(0);
            if (i >= 3) check("b2b_vld", 32'(out_valid_v[0]), 32'(i >= 4 && i <= 6));
            if (i >= 4 && i <= 6) check("b2b_res", 32'({cout_v[0], sum_v[0]}), 32'(tr[i-4]));
        end
        check("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Full pipe, consumer stalls three cycles while a fifth operand waits
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i < 4)       drive(0, 1'b1, sa[i], sb[i], 1'b0, 1'b1);
            else if (i < 7)  drive(0, 1'b1, sa[4], sb[4], 1'b0, 1'b0);
            else if (i == 7) drive(0, 1'b1, sa[4], sb[4], 1'b0, 1'b1);
            else             drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            step(0);
            if (i == 4) begin
                hold_s = sum_v[0];
                hold_c = cout_v[0];
                check("stall_vld", 32'(out_valid_v[0]), 32'd1);
                check("stall_rdy", 32'(in_ready_v[0]), 32'd0);
            end
            if (i == 5 || i == 6) begin
                check("stall_sum", 32'(sum_v[0]), 32'(hold_s));
                check("stall_cout", 32'(cout_v[0]), 32'(hold_c));
                check("stall_vld", 32'(out_valid_v[0]), 32'd1);
                check("stall_rdy", 32'(in_ready_v[0]), 32'd0);
            end
            if (i >= 7) check("stall_burst", 32'(out_valid_v[0]), 32'(i <= 11));
        end
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // Reset with two transactions in flight
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 1'b1, sa[i], sb[i], 1'b1, 1'b1);
            step(0);
        end
        @(negedge clk);
        rst_n         = 1'b0;
        in_valid_v[0] = 1'b0;
        #1;
        check("mrst_in_ready", 32'(in_ready_v[0]), 32'd0);
        @(negedge clk);
        #1;
        check("mrst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("mrst_sum", 32'(sum_v[0]), 32'd0);
        check("mrst_cout", 32'(cout_v[0]), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            step(0);
            check("mrst_quiet", 32'(out_valid_v[0]), 32'd0);
        end
        single(0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "post_rst");

        rand_run(0);
        rand_run(1);
        rand_run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
